step_clock_ctrl: RTL and testbench



---
 rtl/step_clock_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_step_clock_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_ctrl.sv
// -----------------------------------------------------------------------------
// step_clock_ctrl
//
// Purpose:
//   Drives the CPU from the 50 MHz board clock with a one-cycle clock-enable
//   pulse instead of a derived clock. The processor either free-runs at a
//   fixed divided rate (RUN) or advances one step for each debounced press of
//   the step button (STEP). The mode button toggles between the two. A step
//   counter reports how many enable pulses have been issued since reset.
//
// Ports:
//   clk         in   50 MHz board clock
//   rst         in   synchronous, active-high reset
//   key_step_n  in   raw step button, active low, asynchronous to clk
//   key_mode_n  in   raw mode button, active low, asynchronous to clk
//   cpu_en      out  one-clk-wide enable pulse to the CPU pipeline
//   run_mode    out  1 = RUN, 0 = STEP
//   step_count  out  [CNT_W-1:0] cpu_en pulses issued since reset (wraps)
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a key change
//   RUN_PERIOD       clk cycles between cpu_en pulses in RUN mode
//   CNT_W            width of step_count
//
// Build option:
//   STEP_CTRL_AUTOREPEAT_EN  when defined, holding the step key in STEP mode
//                            auto-repeats: after the key has stayed down for
//                            8*DEBOUNCE_CYCLES cycles past its press, an extra
//                            pulse is issued every DEBOUNCE_CYCLES cycles until
//                            release. A mode press cancels the repeat. When
//                            undefined, each press gives exactly one pulse and
//                            the repeat counter does not exist.
// -----------------------------------------------------------------------------
module step_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_PERIOD      = 33554432,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_step_n,
  input  logic             key_mode_n,
  output logic             cpu_en,
  output logic             run_mode,
  output logic [CNT_W-1:0] step_count
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_PERIOD - 1);

  // Key index 0 is the step button, index 1 the mode button.
  localparam int KEY_STEP = 0;
  localparam int KEY_MODE = 1;

  typedef enum logic {
    ST_STEP = 1'b0,
    ST_RUN  = 1'b1
  } mode_state_e;

  logic [1:0]       raw_keys;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       stable;
  logic [1:0]       stable_d;
  logic [DEB_W-1:0] deb_cnt [2];
  logic [1:0]       press;

  logic             step_evt;
  logic             mode_evt;
  logic             rpt_fire;

  mode_state_e      state;
  mode_state_e      state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             en_nxt;

  assign raw_keys = {key_mode_n, key_step_n};

  // ---- Stage p0/p1: two-flop synchronizer, keys idle high ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
    end else begin
      sync_p0 <= raw_keys;
      sync_p1 <= sync_p0;
    end
  end

  // ---- Debounce: accept a level only after DEBOUNCE_CYCLES mismatches ----
  // The counter tracks how long the synced level has disagreed with the
  // accepted level; any agreement restarts it, so short glitches never land.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable   <= 2'b11;
      stable_d <= 2'b11;
      for (int k = 0; k < 2; k++) begin
        deb_cnt[k] <= '0;
      end
    end else begin
      stable_d <= stable;
      for (int k = 0; k < 2; k++) begin
        if (sync_p1[k] == stable[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          stable[k]  <= sync_p1[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
        end
      end
    end
  end

  // A press is the cycle right after the accepted level falls; releases are
  // deliberately ignored.
  assign press    = stable_d & ~stable;
  assign step_evt = press[KEY_STEP];
  assign mode_evt = press[KEY_MODE];

`ifdef STEP_CTRL_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(8 * DEBOUNCE_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_HOLD_LAST = RPT_W'(8 * DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_RATE_LAST = RPT_W'(DEBOUNCE_CYCLES - 1);

  logic             rpt_arm;
  logic             rpt_fast;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_due;

  // The first repeat waits the long hold delay; later ones use the short rate.
  assign rpt_due  = rpt_fast ? (rpt_cnt == RPT_RATE_LAST)
                             : (rpt_cnt == RPT_HOLD_LAST);
  assign rpt_fire = rpt_arm && rpt_due && (state == ST_STEP) && !stable[KEY_STEP];

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_arm  <= 1'b0;
      rpt_fast <= 1'b0;
      rpt_cnt  <= '0;
    end else if (mode_evt || (state != ST_STEP) || stable[KEY_STEP]) begin
      rpt_arm  <= 1'b0;
      rpt_fast <= 1'b0;
      rpt_cnt  <= '0;
    end else if (step_evt) begin
      rpt_arm  <= 1'b1;
      rpt_fast <= 1'b0;
      rpt_cnt  <= '0;
    end else if (rpt_arm) begin
      if (rpt_due) begin
        rpt_cnt  <= '0;
        rpt_fast <= 1'b1;
      end else begin
        rpt_cnt  <= rpt_cnt + RPT_W'(1);
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // ---- Mode FSM and divider: next-state logic ----
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    en_nxt    = 1'b0;
    if (mode_evt) begin
      // A mode press wins over a same-cycle step press and over a divider
      // wrap, so switching modes never emits a pulse.
      state_nxt = (state == ST_RUN) ? ST_STEP : ST_RUN;
      div_nxt   = '0;
    end else if (state == ST_RUN) begin
      if (div_cnt == DIV_LAST) begin
        div_nxt = '0;
        en_nxt  = 1'b1;
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
      end
    end else begin
      div_nxt = '0;
      en_nxt  = step_evt | rpt_fire;
    end
    // Back-to-back enables are never allowed, whatever the parameters.
    if (cpu_en) begin
      en_nxt = 1'b0;
    end
  end

  // ---- Registered state, enable pulse and step counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_STEP;
      div_cnt    <= '0;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      cpu_en     <= en_nxt;
      step_count <= step_count + {{(CNT_W-1){1'b0}}, cpu_en};
    end
  end

  assign run_mode = (state == ST_RUN);

endmodule

// File: tb/tb_step_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_step_clock_ctrl
//
// Bench for step_clock_ctrl with DEBOUNCE_CYCLES=4, RUN_PERIOD=8 and a narrow
// CNT_W=8 so the step counter wrap is reachable in a short run.
// A reference model predicts every cpu_en pulse from the raw key samples:
// a key level is accepted once the last DEBOUNCE_CYCLES synchronized samples
// all disagree with it; RUN pulses fall on multiples of RUN_PERIOD after
// entry. Predicted pulses go into a queue; a monitor pops them when the DUT
// shows cpu_en and also compares run_mode and step_count every cycle.
// Directed steps add hand-computed checks for latency, glitches, RUN cadence,
// mode/step collision, counter wrap and mid-run reset.
// -----------------------------------------------------------------------------
module tb_step_clock_ctrl;

  localparam int DEB = 4;
  localparam int RP  = 8;
  localparam int CW  = 8;
  localparam int CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_step_n = 1'b1;
  logic          key_mode_n = 1'b1;
  logic          cpu_en;
  logic          run_mode;
  logic [CW-1:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;

  step_clock_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_PERIOD     (RP),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_step_n(key_step_n),
    .key_mode_n(key_mode_n),
    .cpu_en    (cpu_en),
    .run_mode  (run_mode),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Reference model state (written only by the model process)
  int cyc = 0;
  bit m_run = 1'b0;
  bit m_step_evt = 1'b0;
  bit m_mode_evt = 1'b0;
  bit m_en_prev = 1'b0;
  bit st_step = 1'b1;
  bit st_mode = 1'b1;
  int m_entry = 0;
  int m_pulses = 0;
  int m_exp_count = 0;
  int hs[$];
  int hm[$];

  // Scoreboard: edge at which a pulse is due, and step_count shown with it
  int exp_edge[$];
  int exp_cnt[$];

  int last_pulse_edge = -1;
  int pulses_seen = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model, evaluated at each rising edge
  initial begin
    bit en;
    bit all_s;
    bit all_m;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_run = 1'b0;
        m_step_evt = 1'b0;
        m_mode_evt = 1'b0;
        m_en_prev = 1'b0;
        st_step = 1'b1;
        st_mode = 1'b1;
        m_pulses = 0;
        m_exp_count = 0;
        hs.delete();
        hm.delete();
        for (int i = 0; i < DEB + 2; i++) begin
          hs.push_back(1);
          hm.push_back(1);
        end
      end else begin
        en = 1'b0;
        if (m_mode_evt) begin
          m_run = !m_run;
          if (m_run) m_entry = cyc;
        end else if (m_run) begin
          en = ((cyc - m_entry) % RP) == 0;
        end else begin
          en = m_step_evt;
        end
        if (en && m_en_prev) en = 1'b0;
        m_exp_count = m_pulses;
        if (en) begin
          exp_edge.push_back(cyc);
          exp_cnt.push_back(m_pulses);
          m_pulses = (m_pulses + 1) % CNT_MOD;
        end
        m_en_prev = en;

        // Samples two edges old are what the debouncer sees now.
        hs.push_back(int'(key_step_n));
        void'(hs.pop_front());
        hm.push_back(int'(key_mode_n));
        void'(hm.pop_front());
        all_s = 1'b1;
        all_m = 1'b1;
        for (int i = 0; i < DEB; i++) begin
          if (hs[i] == int'(st_step)) all_s = 1'b0;
          if (hm[i] == int'(st_mode)) all_m = 1'b0;
        end
        m_step_evt = 1'b0;
        m_mode_evt = 1'b0;
        if (all_s) begin
          st_step = !st_step;
          m_step_evt = (st_step == 1'b0);
        end
        if (all_m) begin
          st_mode = !st_mode;
          m_mode_evt = (st_mode == 1'b0);
        end
      end
    end
  end

  // Monitor: per-cycle compare plus scoreboard pop on each pulse
  initial begin
    int e;
    int c;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("run_mode", int'(run_mode), int'(m_run));
        check("step_count", int'(step_count), m_exp_count);
        check("cpu_en_known", int'($isunknown(cpu_en)), 0);
        while (exp_edge.size() > 0 && exp_edge[0] < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missed_pulse: cpu_en stayed 0, expected pulse after edge %0d", exp_edge[0]);
          void'(exp_edge.pop_front());
          void'(exp_cnt.pop_front());
        end
        if (cpu_en === 1'b1) begin
          pulses_seen++;
          last_pulse_edge = cyc;
          if (exp_edge.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: cpu_en=1 after edge %0d, expected 0", cyc);
          end else begin
            e = exp_edge.pop_front();
            c = exp_cnt.pop_front();
            check("pulse_edge", cyc, e);
            check("pulse_count", int'(step_count), c);
          end
        end
      end
    end
  end

  // Stimulus and directed checks
  initial begin
    int n_edge;
    int m_edge;
    int base;
    int base_p;
    int ok;
    int r;

    // Reset held for three edges with keys released
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_cpu_en", int'(cpu_en), 0);
      check("rst_run_mode", int'(run_mode), 0);
      check("rst_step_count", int'(step_count), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cpu_en", int'(cpu_en), 0);
    check("post_rst_run_mode", int'(run_mode), 0);
    check("post_rst_step_count", int'(step_count), 0);

    // Clean step press: pulse visible after edge N+DEB+2
    n_edge = cyc + 1;
    key_step_n = 1'b0;
    tick(20);
    key_step_n = 1'b1;
    tick(20);
    check("clean_latency", last_pulse_edge, n_edge + DEB + 2);
    check("clean_pulses", pulses_seen, 1);
    check("clean_count", int'(step_count), 1);

    // Glitch shorter than DEB is rejected, DEB+1 is accepted
    base_p = pulses_seen;
    key_step_n = 1'b0;
    tick(3);
    key_step_n = 1'b1;
    tick(20);
    check("glitch3_pulses", pulses_seen - base_p, 0);
    check("glitch3_count", int'(step_count), 1);
    key_step_n = 1'b0;
    tick(5);
    key_step_n = 1'b1;
    tick(20);
    check("glitch5_pulses", pulses_seen - base_p, 1);
    check("glitch5_count", int'(step_count), 2);

    // Enter RUN; first pulse RP cycles after entry, step presses ignored
    key_mode_n = 1'b0;
    ok = 0;
    for (int k = 0; k < 20 && ok == 0; k++) begin
      @(negedge clk);
      if (run_mode === 1'b1) ok = 1;
    end
    key_mode_n = 1'b1;
    check("run_entry_seen", ok, 1);
    m_edge = cyc;
    base = int'(step_count);
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      if (k == RP - 1) check("run_no_early_pulse", int'(cpu_en), 0);
      if (k == RP) check("run_first_pulse", int'(cpu_en), 1);
      if (k == 20) key_step_n = 1'b0;
      if (k == 26) key_step_n = 1'b1;
    end
    check("run_ten_pulses", int'(step_count), (base + 10) % CNT_MOD);

    // Mode and step pressed together in RUN: leave RUN, no pulse from either
    key_mode_n = 1'b0;
    key_step_n = 1'b0;
    ok = 0;
    for (int k = 0; k < 20 && ok == 0; k++) begin
      @(negedge clk);
      if (run_mode === 1'b0) ok = 1;
    end
    check("collision_exit_seen", ok, 1);
    tick(4);
    key_mode_n = 1'b1;
    key_step_n = 1'b1;
    base = int'(step_count);
    base_p = pulses_seen;
    tick(20);
    check("collision_no_pulse", pulses_seen - base_p, 0);
    check("collision_count_held", int'(step_count), base);
    key_step_n = 1'b0;
    tick(8);
    key_step_n = 1'b1;
    tick(12);
    check("after_collision_step", int'(step_count), (base + 1) % CNT_MOD);

    // Randomized key activity with occasional resets (keys may be held
    // across reset release)
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        key_step_n = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(int'($urandom_range(1, 2)));
        rst = 1'b0;
        tick(8);
        key_step_n = 1'b1;
        tick(10);
      end else begin
        key_step_n = logic'($urandom_range(0, 1));
        key_mode_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        tick(int'($urandom_range(1, 12)));
        key_step_n = 1'b1;
        key_mode_n = 1'b1;
        tick(int'($urandom_range(0, 15)));
      end
    end

    // Return to a known STEP state
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("renorm_count", int'(step_count), 0);

    // Counter wrap in RUN: all-ones -> 0 on the next pulse
    key_mode_n = 1'b0;
    ok = 0;
    for (int k = 0; k < 20 && ok == 0; k++) begin
      @(negedge clk);
      if (run_mode === 1'b1) ok = 1;
    end
    key_mode_n = 1'b1;
    check("wrap_run_entry_seen", ok, 1);
    ok = 0;
    for (int k = 0; k < 3000 && ok == 0; k++) begin
      @(negedge clk);
      if (int'(step_count) == CNT_MOD - 1) ok = 1;
    end
    check("wrap_reached_max", ok, 1);
    ok = 0;
    for (int k = 0; k < 20 && ok == 0; k++) begin
      @(negedge clk);
      if (cpu_en === 1'b1) ok = 1;
    end
    check("wrap_pulse_seen", ok, 1);
    @(negedge clk);
    check("wrap_to_zero", int'(step_count), 0);

    // Reset mid-divider in RUN
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_run_mode", int'(run_mode), 0);
    check("midrun_rst_count", int'(step_count), 0);
    check("midrun_rst_cpu_en", int'(cpu_en), 0);
    base_p = pulses_seen;
    tick(20);
    check("midrun_rst_quiet", pulses_seen - base_p, 0);
    check("midrun_rst_count_held", int'(step_count), 0);

    tick(5);
    check("scoreboard_drained", exp_edge.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
